// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sadd_state_t;

  localparam int SADD_WIDTH_DEF = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder: the single datapath cell sequenced by serial_adder_ctrl.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder reused over WIDTH clocks, LSB first, with
// valid/ready handshakes on the operand and result sides.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SADD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sadd_state_t      state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic             fsum;
  logic             fcarry_out;

  full_adder FA0 (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fsum),
    .cout (fcarry_out)
  );

  // Handshake flags depend on state only, so no input reaches an output combinationally.
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // NOTE: every register here uses <= so all updates see the pre-edge values;
  // blocking assignments would make the shift and the adder inputs race.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= op_a;
            b_sh   <= op_b;
            carry  <= cin;
            cnt    <= '0;
            sum_sh <= '0;
            state  <= RUN;
          end
        end

        RUN: begin
          sum_sh <= {fsum, sum_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fcarry_out;
          if (cnt == CNT_LAST) begin
            // Capture the finished word straight into the output registers;
            // they then hold through DONE and beyond until the next result.
            sum   <= {fsum, sum_sh[WIDTH-1:1]};
            cout  <= fcarry_out;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table, corner
// sequences, and a random back-to-back stream against an arithmetic model.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int failures = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid with a bound; returns edges elapsed since the call.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Starts in IDLE at #1 after an edge; accepts, checks latency and result, handshakes.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W:0] exp);
    int lat;
    check({name, "_in_ready"}, in_ready, 1);
    op_a = a; op_b = b; cin = c; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_result(lat);
    check({name, "_latency"}, lat, W);
    check({name, "_result"}, {cout, sum}, exp);
    tick();
    check({name, "_released"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [W:0] exp;
    logic [W:0] held;
    int lat;

    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h01, 8'hFE, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};

    #12;
    check("reset_outputs", {out_valid, in_ready, busy, cout, sum}, {3'b010, 1'b0, 8'h00});
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c,
             {vecs[i].exp_cout, vecs[i].exp_sum});

    // Backpressure: result held in DONE, concurrent operands ignored.
    op_a = 8'h35; op_b = 8'h4A; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_result(lat);
    check("bp_latency", lat, W);
    op_a = 8'hAA; op_b = 8'h11; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold%0d", i), {out_valid, in_ready, busy, cout, sum}, {3'b101, 1'b0, 8'h7F});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_handshake", {out_valid, in_ready, busy}, 3'b010);
    tick();
    check("bp_no_accept", {busy, cout, sum}, {1'b0, 1'b0, 8'h7F});

    // Operands changed mid-RUN do not affect the result.
    op_a = 8'h10; op_b = 8'h20; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; op_a = 8'h00; op_b = 8'hFF; cin = 1'b1;
    wait_result(lat);
    check("midrun_result", {cout, sum}, 9'h030);
    tick();

    // Reset in RUN after 4 bits: operation discarded.
    op_a = 8'hFF; op_b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rst_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async", {out_valid, in_ready, busy, cout, sum}, {3'b010, 1'b0, 8'h00});
    tick();
    rst_n = 1'b1;
    held = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) held = 9'h1FF;
    end
    check("rst_no_result", held, 0);
    run_op("post_rst", 8'h01, 8'h01, 1'b0, 9'h002);

    // Random back-to-back stream with in_valid and out_ready held high.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      exp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      check("stream_ready", in_ready, 1);
      op_a = ra; op_b = rb; cin = rc;
      tick();
      op_a = ~ra; op_b = ~rb; cin = ~rc;
      wait_result(lat);
      check("stream_period", lat + 2, W + 2);
      check("stream_result", {cout, sum}, exp);
      tick();
      if (failures > 50) break;
    end
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
